damage_calc: RTL and testbench
==============================

# damage_calc

Combat-resolution datapath for the battle engine. It sums the 16 per-slot friendly unit attack values and the 16 per-slot enemy attack values into two 12-bit damage totals. It uses a Start/Done/Ack handshake with the game-control FSM. The control FSM drives the attack buses and reads the totals once Done is asserted.

## Interface
- No parameters. Slot count is fixed at 16, attack width at 8 bits, total width at 12 bits.
- Clocking: one clock; reset is synchronous and active-high.
- clk  in  1  system clock; all state changes on rising edge.
- rst  in  1  synchronous active-high reset.
- Start  in  1  request a computation; sampled only in INIT.
- Ack  in  1  consumer has read results; sampled only in DONE.
- unitAttack0 … unitAttack15  in  8 each  friendly per-slot attack, unsigned.
- enemyAttack0 … enemyAttack15  in  8 each  enemy per-slot attack, unsigned.
- totalUnitDamage  out  12  sum of unitAttack0..15, unsigned.
- totalEnemyDamage  out  12  sum of enemyAttack0..15, unsigned.
- Done  out  1  high exactly while the state is DONE.

## Operation
- State machine with three states:
  - INIT (reset state): totals hold their last value. If Start=1, clear both totals, clear the 4-bit slot index to 0, and go to COMPUTE.
  - COMPUTE: each cycle, totalUnitDamage += unitAttack[idx] and totalEnemyDamage += enemyAttack[idx], then idx += 1. On the cycle where idx==15, perform the final add and go to DONE.
  - DONE: Done=1 and totals are held. If Ack=1, go to INIT. Totals stay valid in INIT until the next Start.
- Slot select is a 16:1 mux on idx for each side. Inputs are not latched; the attack buses must be stable from the Start cycle until Done.
- Arithmetic: each 8-bit value is zero-extended to 12 bits. The maximum sum is 16×255 = 4080, which fits, so overflow cannot occur and no saturation logic is needed.
- Start while in COMPUTE or DONE is ignored. Ack outside DONE is ignored.
- Start and Ack high together in INIT: Start wins and Ack is ignored.
- Reset at any time, including mid-COMPUTE or in DONE: on the next edge, state=INIT, idx=0, totals=0, Done=0. The partial sum is discarded.

## Timing
- Reset values: totalUnitDamage=0, totalEnemyDamage=0, Done=0, state INIT, idx=0.
- Edge E0 samples Start=1 and moves INIT→COMPUTE. Slot k is accumulated at edge E(k+1), for k=0..15.
- At edge E16, the final accumulation happens and the state moves to DONE. Done is high and the totals are final from E16 onward. Latency is 16 clocks from the Start-sampling edge.
- Done stays high until the edge that samples Ack=1. From the next cycle Done=0 and the state is INIT.
- A new Start can be accepted on the cycle after returning to INIT. Minimum period per computation is 18 clocks (Start + 16 compute + Ack).
- Outputs are registered. There is no combinational path from inputs to Done or to the totals.

## Test plan
- Nominal run: unitAttack0=0, unitAttack1..15=10; enemyAttack0=0, enemyAttack12=0, all other enemy slots=10; pulse Start, wait for Done, pulse Ack. Required: totalUnitDamage=150, totalEnemyDamage=140, Done 16 clocks after Start is sampled, Done low after Ack.
- Zero run: all attack inputs 0, issued directly after the nominal run. Required: both totals are 0, which proves the totals are cleared on Start, and latency is 16 clocks.
- Maximum and ramp: all unit slots=255 and enemy slot k=k+1. Required: totalUnitDamage=4080 (no wrap) and totalEnemyDamage=136.
- Handshake robustness:
  - Hold Done for 10 cycles without Ack: Done and totals stay stable.
  - Pulse Start during COMPUTE and during DONE: no effect.
  - Pulse Ack in INIT: no effect.
- Reset mid-operation: assert rst at compute cycle 7 for one cycle. Required: totals=0 and Done=0 the next cycle, state INIT. A following Start with nominal data yields 150/140.
- Reset values: after power-on rst, before any Start, both totals are 0 and Done is 0.

Source files
------------

// File: rtl/damage_calc.sv
// Combat-resolution datapath: serially accumulates 16 friendly and 16 enemy
// attack slots into two 12-bit totals behind a Start/Done/Ack handshake.
module damage_calc (
  input  logic        clk,
  input  logic        rst,
  input  logic        Start,
  input  logic        Ack,
  input  logic [7:0]  unitAttack0,
  input  logic [7:0]  unitAttack1,
  input  logic [7:0]  unitAttack2,
  input  logic [7:0]  unitAttack3,
  input  logic [7:0]  unitAttack4,
  input  logic [7:0]  unitAttack5,
  input  logic [7:0]  unitAttack6,
  input  logic [7:0]  unitAttack7,
  input  logic [7:0]  unitAttack8,
  input  logic [7:0]  unitAttack9,
  input  logic [7:0]  unitAttack10,
  input  logic [7:0]  unitAttack11,
  input  logic [7:0]  unitAttack12,
  input  logic [7:0]  unitAttack13,
  input  logic [7:0]  unitAttack14,
  input  logic [7:0]  unitAttack15,
  input  logic [7:0]  enemyAttack0,
  input  logic [7:0]  enemyAttack1,
  input  logic [7:0]  enemyAttack2,
  input  logic [7:0]  enemyAttack3,
  input  logic [7:0]  enemyAttack4,
  input  logic [7:0]  enemyAttack5,
  input  logic [7:0]  enemyAttack6,
  input  logic [7:0]  enemyAttack7,
  input  logic [7:0]  enemyAttack8,
  input  logic [7:0]  enemyAttack9,
  input  logic [7:0]  enemyAttack10,
  input  logic [7:0]  enemyAttack11,
  input  logic [7:0]  enemyAttack12,
  input  logic [7:0]  enemyAttack13,
  input  logic [7:0]  enemyAttack14,
  input  logic [7:0]  enemyAttack15,
  output logic [11:0] totalUnitDamage,
  output logic [11:0] totalEnemyDamage,
  output logic        Done
);

  typedef enum logic [1:0] {
    S_INIT    = 2'd0,
    S_COMPUTE = 2'd1,
    S_DONE    = 2'd2
  } state_e;

  state_e      state_q;
  logic [3:0]  idx_q;
  logic [11:0] unit_tot_q;
  logic [11:0] enemy_tot_q;
  logic        done_q;

  logic [7:0]  unit_arr_s  [16];
  logic [7:0]  enemy_arr_s [16];
  logic [7:0]  unit_sel_s;
  logic [7:0]  enemy_sel_s;
  logic [11:0] unit_sum_d;
  logic [11:0] enemy_sum_d;

  assign unit_arr_s[0]   = unitAttack0;
  assign unit_arr_s[1]   = unitAttack1;
  assign unit_arr_s[2]   = unitAttack2;
  assign unit_arr_s[3]   = unitAttack3;
  assign unit_arr_s[4]   = unitAttack4;
  assign unit_arr_s[5]   = unitAttack5;
  assign unit_arr_s[6]   = unitAttack6;
  assign unit_arr_s[7]   = unitAttack7;
  assign unit_arr_s[8]   = unitAttack8;
  assign unit_arr_s[9]   = unitAttack9;
  assign unit_arr_s[10]  = unitAttack10;
  assign unit_arr_s[11]  = unitAttack11;
  assign unit_arr_s[12]  = unitAttack12;
  assign unit_arr_s[13]  = unitAttack13;
  assign unit_arr_s[14]  = unitAttack14;
  assign unit_arr_s[15]  = unitAttack15;
  assign enemy_arr_s[0]  = enemyAttack0;
  assign enemy_arr_s[1]  = enemyAttack1;
  assign enemy_arr_s[2]  = enemyAttack2;
  assign enemy_arr_s[3]  = enemyAttack3;
  assign enemy_arr_s[4]  = enemyAttack4;
  assign enemy_arr_s[5]  = enemyAttack5;
  assign enemy_arr_s[6]  = enemyAttack6;
  assign enemy_arr_s[7]  = enemyAttack7;
  assign enemy_arr_s[8]  = enemyAttack8;
  assign enemy_arr_s[9]  = enemyAttack9;
  assign enemy_arr_s[10] = enemyAttack10;
  assign enemy_arr_s[11] = enemyAttack11;
  assign enemy_arr_s[12] = enemyAttack12;
  assign enemy_arr_s[13] = enemyAttack13;
  assign enemy_arr_s[14] = enemyAttack14;
  assign enemy_arr_s[15] = enemyAttack15;

  // Slot mux and next partial sums; 16 x 255 = 4080 fits in 12 bits, so no wrap.
  always_comb begin
    unit_sel_s  = unit_arr_s[idx_q];
    enemy_sel_s = enemy_arr_s[idx_q];
    unit_sum_d  = unit_tot_q + {4'd0, unit_sel_s};
    enemy_sum_d = enemy_tot_q + {4'd0, enemy_sel_s};
  end

  // Control FSM with registered totals and Done.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_INIT;
      idx_q       <= 4'd0;
      unit_tot_q  <= 12'd0;
      enemy_tot_q <= 12'd0;
      done_q      <= 1'b0;
    end else begin
      case (state_q)
        S_INIT: begin
          done_q <= 1'b0;
          if (Start) begin
            unit_tot_q  <= 12'd0;
            enemy_tot_q <= 12'd0;
            idx_q       <= 4'd0;
            state_q     <= S_COMPUTE;
          end
        end
        S_COMPUTE: begin
          unit_tot_q  <= unit_sum_d;
          enemy_tot_q <= enemy_sum_d;
          idx_q       <= idx_q + 4'd1;
          if (idx_q == 4'd15) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
          end
        end
        S_DONE: begin
          if (Ack) begin
            state_q <= S_INIT;
            done_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= S_INIT;
          idx_q   <= 4'd0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign totalUnitDamage  = unit_tot_q;
  assign totalEnemyDamage = enemy_tot_q;
  assign Done             = done_q;

endmodule

// File: tb/tb_damage_calc.sv
// Self-checking bench for damage_calc: directed and random runs compared
// against plain-arithmetic sums of the slot arrays.
module tb_damage_calc;

  logic        clk;
  logic        rst;
  logic        Start;
  logic        Ack;
  logic [7:0]  ua [16];
  logic [7:0]  ea [16];
  logic [11:0] totalUnitDamage;
  logic [11:0] totalEnemyDamage;
  logic        Done;

  int checks;
  int failures;

  damage_calc dut (
    .clk(clk), .rst(rst), .Start(Start), .Ack(Ack),
    .unitAttack0(ua[0]),   .unitAttack1(ua[1]),   .unitAttack2(ua[2]),   .unitAttack3(ua[3]),
    .unitAttack4(ua[4]),   .unitAttack5(ua[5]),   .unitAttack6(ua[6]),   .unitAttack7(ua[7]),
    .unitAttack8(ua[8]),   .unitAttack9(ua[9]),   .unitAttack10(ua[10]), .unitAttack11(ua[11]),
    .unitAttack12(ua[12]), .unitAttack13(ua[13]), .unitAttack14(ua[14]), .unitAttack15(ua[15]),
    .enemyAttack0(ea[0]),   .enemyAttack1(ea[1]),   .enemyAttack2(ea[2]),   .enemyAttack3(ea[3]),
    .enemyAttack4(ea[4]),   .enemyAttack5(ea[5]),   .enemyAttack6(ea[6]),   .enemyAttack7(ea[7]),
    .enemyAttack8(ea[8]),   .enemyAttack9(ea[9]),   .enemyAttack10(ea[10]), .enemyAttack11(ea[11]),
    .enemyAttack12(ea[12]), .enemyAttack13(ea[13]), .enemyAttack14(ea[14]), .enemyAttack15(ea[15]),
    .totalUnitDamage(totalUnitDamage),
    .totalEnemyDamage(totalEnemyDamage),
    .Done(Done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic load_nominal();
    for (int i = 0; i < 16; i++) begin
      ua[i] = (i == 0) ? 8'd0 : 8'd10;
      ea[i] = (i == 0 || i == 12) ? 8'd0 : 8'd10;
    end
  endtask

  // One full transaction. glitch_cyc>0 pulses Start during that compute cycle;
  // during the hold window Start is also pulsed once while in DONE.
  task automatic run_calc(input string tag, input int glitch_cyc, input int hold_cyc,
                          input bit ack_with_start);
    int lat;
    int eu;
    int ee;
    eu = 0;
    ee = 0;
    for (int i = 0; i < 16; i++) begin
      eu += int'(ua[i]);
      ee += int'(ea[i]);
    end
    @(negedge clk);
    Start = 1'b1;
    Ack   = ack_with_start;
    @(posedge clk);
    #1;
    Start = 1'b0;
    Ack   = 1'b0;
    lat = 0;
    while (lat < 40) begin
      Start = (glitch_cyc > 0 && lat + 1 == glitch_cyc);
      @(posedge clk);
      #1;
      Start = 1'b0;
      lat++;
      if (Done === 1'b1) break;
    end
    check_value({tag, ".latency"}, lat, 16);
    check_value({tag, ".unit"}, totalUnitDamage, eu);
    check_value({tag, ".enemy"}, totalEnemyDamage, ee);
    for (int h = 0; h < hold_cyc; h++) begin
      Start = (h == 2);
      @(posedge clk);
      #1;
      Start = 1'b0;
      check_value({tag, ".hold_done"}, Done, 1);
      check_value({tag, ".hold_unit"}, totalUnitDamage, eu);
    end
    @(negedge clk);
    Ack = 1'b1;
    @(posedge clk);
    #1;
    Ack = 1'b0;
    check_value({tag, ".done_after_ack"}, Done, 0);
    check_value({tag, ".unit_after_ack"}, totalUnitDamage, eu);
    check_value({tag, ".enemy_after_ack"}, totalEnemyDamage, ee);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst   = 1'b1;
    Start = 1'b0;
    Ack   = 1'b0;
    for (int i = 0; i < 16; i++) begin
      ua[i] = 8'd0;
      ea[i] = 8'd0;
    end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check_value("reset.unit", totalUnitDamage, 0);
    check_value("reset.enemy", totalEnemyDamage, 0);
    check_value("reset.done", Done, 0);
    repeat (3) @(posedge clk);
    #1;
    check_value("idle.done", Done, 0);

    load_nominal();
    run_calc("nominal", 0, 0, 1'b0);
    check_value("nominal.unit_abs", totalUnitDamage, 150);
    check_value("nominal.enemy_abs", totalEnemyDamage, 140);

    for (int i = 0; i < 16; i++) begin
      ua[i] = 8'd0;
      ea[i] = 8'd0;
    end
    run_calc("zero", 0, 0, 1'b0);

    for (int i = 0; i < 16; i++) begin
      ua[i] = 8'd255;
      ea[i] = 8'(i + 1);
    end
    run_calc("maxramp", 0, 0, 1'b0);
    check_value("maxramp.unit_abs", totalUnitDamage, 4080);
    check_value("maxramp.enemy_abs", totalEnemyDamage, 136);

    load_nominal();
    run_calc("robust", 5, 10, 1'b0);

    @(negedge clk);
    Ack = 1'b1;
    @(posedge clk);
    #1;
    Ack = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_value("ack_in_init.done", Done, 0);
    check_value("ack_in_init.unit", totalUnitDamage, 150);

    for (int i = 0; i < 16; i++) begin
      ua[i] = 8'($urandom_range(0, 255));
      ea[i] = 8'($urandom_range(0, 255));
    end
    run_calc("start_ack_together", 0, 0, 1'b1);

    @(negedge clk);
    Start = 1'b1;
    @(posedge clk);
    #1;
    Start = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_value("midreset.unit", totalUnitDamage, 0);
    check_value("midreset.enemy", totalEnemyDamage, 0);
    check_value("midreset.done", Done, 0);
    repeat (20) @(posedge clk);
    #1;
    check_value("midreset.stays_init", Done, 0);
    check_value("midreset.unit_held", totalUnitDamage, 0);
    load_nominal();
    run_calc("after_reset", 0, 0, 1'b0);
    check_value("after_reset.unit_abs", totalUnitDamage, 150);
    check_value("after_reset.enemy_abs", totalEnemyDamage, 140);

    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < 16; i++) begin
        ua[i] = 8'($urandom_range(0, 255));
        ea[i] = 8'($urandom_range(0, 255));
      end
      run_calc("random", int'($urandom_range(0, 16)), int'($urandom_range(0, 3)), 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
